// File: rtl/sram_chk_pkg.sv
// ---------------------------------------------------------------------------
// sram_chk_pkg
//
// Shared types and helpers for the SRAM read-path checker.
//   rd_pipe_t  : one in-flight read {addr, expected, valid, oor}
//   MAX_RD_LAT : deepest read latency the checker supports
//   sat_inc    : saturating increment for counters of any width <= MAX_CNT_W
//
// The struct fields are sized for the widest configuration; instances with
// narrower addresses or data zero-extend into them and the unused upper bits
// are trimmed away by synthesis.
// ---------------------------------------------------------------------------
package sram_chk_pkg;

  localparam int MAX_RD_LAT  = 4;
  localparam int PIPE_ADDR_W = 32;
  localparam int PIPE_DATA_W = 64;
  localparam int MAX_CNT_W   = 32;

  typedef struct packed {
    logic [PIPE_ADDR_W-1:0] addr;
    logic [PIPE_DATA_W-1:0] expected;
    logic                   valid;
    logic                   oor;
  } rd_pipe_t;

  // Returns val+1, or val unchanged once it has reached 2**width-1.
  function automatic logic [MAX_CNT_W-1:0] sat_inc(input logic [MAX_CNT_W-1:0] val,
                                                    input int                   width);
    logic [MAX_CNT_W:0] lim;
    lim = ((MAX_CNT_W+1)'(1) << width) - (MAX_CNT_W+1)'(1);
    if ({1'b0, val} >= lim) begin
      return val;
    end
    return val + MAX_CNT_W'(1);
  endfunction

endpackage

// File: rtl/sram_chk_pipe.sv
// ---------------------------------------------------------------------------
// sram_chk_pipe
//
// RD_LAT-deep shift register carrying in-flight reads from issue to compare.
// Each stage holds an rd_pipe_t entry plus an occupancy bit so idle
// (write) cycles travel through as bubbles.
//
// Ports:
//   clk      : clock, posedge
//   rst      : asynchronous active-low reset, empties every stage
//   in_live  : a read is being issued this cycle
//   in_ent   : issue-time snapshot of that read
//   out_live : the oldest stage holds a read due for compare
//   out_ent  : the oldest stage's snapshot
// ---------------------------------------------------------------------------
module sram_chk_pipe
  import sram_chk_pkg::*;
#(
  parameter int RD_LAT = 1
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     in_live,
  input  rd_pipe_t in_ent,
  output logic     out_live,
  output rd_pipe_t out_ent
);

  rd_pipe_t          stage [RD_LAT];
  logic [RD_LAT-1:0] live;

  // Stage 0 captures at issue; each edge shifts one stage towards compare.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < RD_LAT; i++) begin
        stage[i] <= '0;
      end
      live <= '0;
    end else begin
      stage[0] <= in_ent;
      live[0]  <= in_live;
      for (int i = 1; i < RD_LAT; i++) begin
        stage[i] <= stage[i-1];
        live[i]  <= live[i-1];
      end
    end
  end

  assign out_live = live[RD_LAT-1];
  assign out_ent  = stage[RD_LAT-1];

endmodule

// File: rtl/sram_rd_checker.sv
// ---------------------------------------------------------------------------
// sram_rd_checker
//
// Read-path checker that sits beside a single-port SRAM. Every in-range write
// is mirrored into a shadow store with a per-word valid bit. Every non-write
// cycle is a read: its expected value is captured at issue, carried RD_LAT
// cycles through sram_chk_pipe, and compared with d_out at the edge the SRAM
// data is due.
//
// Parameters: DATA_W, ADDR_W (<= 32), DEPTH (<= 2**ADDR_W), RD_LAT (1..4),
//             CNT_W (<= 32).
//
// Ports:
//   clk            : clock, posedge
//   rst            : asynchronous active-low reset
//   wren           : 1 = write cycle, 0 = read cycle
//   addr           : SRAM address
//   d_in           : SRAM write data
//   d_out          : SRAM read data being checked
//   clr            : synchronous clear of flags, counters and capture
//   err_mismatch   : sticky, returned data differed from shadow
//   err_uninit     : sticky, read of a word never written since reset
//   err_addr       : sticky, read or write with addr >= DEPTH
//   err_cnt        : saturating count of cycles with any error event
//   rd_cnt         : saturating count of reads that reached compare
//   first_err_addr : address of the first error since reset/clr
//   first_err_vld  : first_err_addr is meaningful
//
// Build option: define SRAM_CHK_SVA_EN to compile in concurrent assertions
// (d_out quiet in reset, no X on checked data, $error on each flag rising).
// ---------------------------------------------------------------------------
module sram_rd_checker
  import sram_chk_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4,
  parameter int DEPTH  = 16,
  parameter int RD_LAT = 1,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wren,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] d_in,
  input  logic [DATA_W-1:0] d_out,
  input  logic              clr,
  output logic              err_mismatch,
  output logic              err_uninit,
  output logic              err_addr,
  output logic [CNT_W-1:0]  err_cnt,
  output logic [CNT_W-1:0]  rd_cnt,
  output logic [ADDR_W-1:0] first_err_addr,
  output logic              first_err_vld
);

  logic              addr_oor;
  logic              wr_ok;
  logic [DATA_W-1:0] shadow [DEPTH];
  logic [DEPTH-1:0]  shadow_vld;
  logic [DATA_W-1:0] rd_exp;
  logic              rd_vld;
  rd_pipe_t          issue_ent;
  logic              cmp_live;
  rd_pipe_t          cmp_ent;
  logic              ev_rd_addr;
  logic              ev_wr_addr;
  logic              ev_uninit;
  logic              ev_mismatch;
  logic              ev_cmp;
  logic              ev_any;
  logic [ADDR_W-1:0] ev_addr;
  logic              unused_pipe_bits;

  assign addr_oor = (32'(addr) >= 32'(DEPTH));
  assign wr_ok    = wren && !addr_oor;

  // Shadow data needs no reset: the valid bits alone decide whether it is
  // trusted, so it can map onto plain registers or a RAM.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (wr_ok && (addr == ADDR_W'(i))) begin
        shadow[i] <= d_in;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shadow_vld <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (wr_ok && (addr == ADDR_W'(i))) begin
          shadow_vld[i] <= 1'b1;
        end
      end
    end
  end

  // Shadow lookup by decode so addresses >= DEPTH simply match nothing.
  always_comb begin
    rd_exp = '0;
    rd_vld = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (addr == ADDR_W'(i)) begin
        rd_exp = shadow[i];
        rd_vld = shadow_vld[i];
      end
    end
  end

  always_comb begin
    issue_ent          = '0;
    issue_ent.addr     = PIPE_ADDR_W'(addr);
    issue_ent.expected = PIPE_DATA_W'(rd_exp);
    issue_ent.valid    = rd_vld;
    issue_ent.oor      = addr_oor;
  end

  sram_chk_pipe #(
    .RD_LAT (RD_LAT)
  ) u_pipe (
    .clk      (clk),
    .rst      (rst),
    .in_live  (!wren),
    .in_ent   (issue_ent),
    .out_live (cmp_live),
    .out_ent  (cmp_ent)
  );

  assign unused_pipe_bits = ^{cmp_ent.addr >> ADDR_W, cmp_ent.expected >> DATA_W};

  // Compare-stage classification: out-of-range beats uninitialised, and only
  // a fully trusted shadow word is compared against d_out.
  assign ev_rd_addr  = cmp_live && cmp_ent.oor;
  assign ev_uninit   = cmp_live && !cmp_ent.oor && !cmp_ent.valid;
  assign ev_mismatch = cmp_live && !cmp_ent.oor && cmp_ent.valid &&
                       (d_out != cmp_ent.expected[DATA_W-1:0]);
  assign ev_wr_addr  = wren && addr_oor;
  assign ev_cmp      = ev_rd_addr || ev_uninit || ev_mismatch;
  assign ev_any      = ev_cmp || ev_wr_addr;

  // A compare-stage error belongs to an older transaction than a same-cycle
  // out-of-range write, so it wins the first-error capture.
  assign ev_addr = ev_cmp ? cmp_ent.addr[ADDR_W-1:0] : addr;

  // Sticky flags, counters and first-error capture; clr overrides any event
  // landing in the same cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_mismatch   <= 1'b0;
      err_uninit     <= 1'b0;
      err_addr       <= 1'b0;
      err_cnt        <= '0;
      rd_cnt         <= '0;
      first_err_addr <= '0;
      first_err_vld  <= 1'b0;
    end else if (clr) begin
      err_mismatch   <= 1'b0;
      err_uninit     <= 1'b0;
      err_addr       <= 1'b0;
      err_cnt        <= '0;
      rd_cnt         <= '0;
      first_err_addr <= '0;
      first_err_vld  <= 1'b0;
    end else begin
      if (ev_mismatch) begin
        err_mismatch <= 1'b1;
      end
      if (ev_uninit) begin
        err_uninit <= 1'b1;
      end
      if (ev_rd_addr || ev_wr_addr) begin
        err_addr <= 1'b1;
      end
      if (cmp_live) begin
        rd_cnt <= CNT_W'(sat_inc(MAX_CNT_W'(rd_cnt), CNT_W));
      end
      if (ev_any) begin
        err_cnt <= CNT_W'(sat_inc(MAX_CNT_W'(err_cnt), CNT_W));
      end
      if (ev_any && !first_err_vld) begin
        first_err_addr <= ev_addr;
        first_err_vld  <= 1'b1;
      end
    end
  end

`ifdef SRAM_CHK_SVA_EN
  a_dout_quiet_in_reset : assert property (@(posedge clk) !rst |-> (d_out == '0))
    else $error("sram_rd_checker: d_out=0x%0h while in reset", $sampled(d_out));

  a_dout_known : assert property (@(posedge clk) disable iff (!rst)
                                  cmp_live |-> !$isunknown(d_out))
    else $error("sram_rd_checker: d_out unknown at compare, addr 0x%0h",
                $sampled(cmp_ent.addr[ADDR_W-1:0]));

  a_mismatch_rise : assert property (@(posedge clk) disable iff (!rst)
                                     !(ev_mismatch && !err_mismatch && !clr))
    else $error("sram_rd_checker: err_mismatch set, addr 0x%0h", $sampled(ev_addr));

  a_uninit_rise : assert property (@(posedge clk) disable iff (!rst)
                                   !(ev_uninit && !err_uninit && !clr))
    else $error("sram_rd_checker: err_uninit set, addr 0x%0h", $sampled(ev_addr));

  a_addr_rise : assert property (@(posedge clk) disable iff (!rst)
                                 !((ev_rd_addr || ev_wr_addr) && !err_addr && !clr))
    else $error("sram_rd_checker: err_addr set, addr 0x%0h", $sampled(ev_addr));
`else
  // Assertion-free build: flag and counter behaviour is identical, no X checks.
`endif

endmodule

// File: tb/tb_sram_rd_checker.sv
// ---------------------------------------------------------------------------
// tb_sram_rd_checker
//
// Directed bench for sram_rd_checker with DEPTH=8, RD_LAT=2, CNT_W=2.
// The bench plays the SRAM itself: each drive() call sets the port for one
// clock, including the d_out value returned at that edge. Every non-write
// cycle is a read, so "idle" cycles are writes of 0 to address 0, which no
// scenario ever reads. Outputs are sampled on the falling edge.
// Status word layout: {mismatch, uninit, addr, first_vld, first_addr[3:0],
//                      err_cnt[1:0], rd_cnt[1:0]}.
// ---------------------------------------------------------------------------
module tb_sram_rd_checker;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       wren = 1'b1;
  logic [3:0] addr = 4'h0;
  logic [7:0] d_in = 8'h00;
  logic [7:0] d_out = 8'h00;
  logic       clr = 1'b0;
  logic       err_mismatch;
  logic       err_uninit;
  logic       err_addr;
  logic [1:0] err_cnt;
  logic [1:0] rd_cnt;
  logic [3:0] first_err_addr;
  logic       first_err_vld;

  int          n_cmp  = 0;
  int          n_fail = 0;
  logic [11:0] got;
  logic [11:0] exp;

  sram_rd_checker #(
    .DATA_W (8),
    .ADDR_W (4),
    .DEPTH  (8),
    .RD_LAT (2),
    .CNT_W  (2)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .wren           (wren),
    .addr           (addr),
    .d_in           (d_in),
    .d_out          (d_out),
    .clr            (clr),
    .err_mismatch   (err_mismatch),
    .err_uninit     (err_uninit),
    .err_addr       (err_addr),
    .err_cnt        (err_cnt),
    .rd_cnt         (rd_cnt),
    .first_err_addr (first_err_addr),
    .first_err_vld  (first_err_vld)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  function automatic logic [11:0] snap();
    return {err_mismatch, err_uninit, err_addr, first_err_vld,
            first_err_addr, err_cnt, rd_cnt};
  endfunction

  // Called at a falling edge: drive one cycle, return at the next falling edge.
  task automatic drive(input logic w, input logic [3:0] a, input logic [7:0] di,
                       input logic [7:0] dq, input logic c);
    wren  = w;
    addr  = a;
    d_in  = di;
    d_out = dq;
    clr   = c;
    @(negedge clk);
  endtask

  task automatic idle(input int n, input logic [7:0] dq);
    for (int i = 0; i < n; i++) begin
      drive(1'b1, 4'h0, 8'h00, dq, 1'b0);
    end
  endtask

  task automatic do_clr();
    drive(1'b1, 4'h0, 8'h00, 8'h00, 1'b1);
  endtask

  task automatic test_reset();
    got = snap(); exp = 12'h000; n_cmp++;
    if (got !== exp) begin
      n_fail++; $display("[TB] FAIL reset_held: got %b, want %b", got, exp);
    end
    rst = 1'b1;
    idle(2, 8'h00);
    got = snap(); exp = 12'h000; n_cmp++;
    if (got !== exp) begin
      n_fail++; $display("[TB] FAIL reset_release: got %b, want %b", got, exp);
    end
  endtask

  task automatic test_uninit();
    drive(1'b0, 4'h7, 8'h00, 8'hFF, 1'b0);
    idle(1, 8'hFF);
    got = snap(); exp = 12'h000; n_cmp++;
    if (got !== exp) begin
      n_fail++; $display("[TB] FAIL uninit_before_due: got %b, want %b", got, exp);
    end
    idle(1, 8'hFF);
    got = snap(); exp = {1'b0, 1'b1, 1'b0, 1'b1, 4'h7, 2'd1, 2'd1}; n_cmp++;
    if (got !== exp) begin
      n_fail++; $display("[TB] FAIL uninit_addr7: got %b, want %b", got, exp);
    end
  endtask

  task automatic test_match();
    do_clr();
    got = snap(); exp = 12'h000; n_cmp++;
    if (got !== exp) begin
      n_fail++; $display("[TB] FAIL clr_after_uninit: got %b, want %b", got, exp);
    end
    drive(1'b1, 4'h3, 8'hA5, 8'h00, 1'b0);
    drive(1'b0, 4'h3, 8'h00, 8'h00, 1'b0);
    idle(1, 8'h00);
    idle(1, 8'hA5);
    got = snap(); exp = {1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 2'd0, 2'd1}; n_cmp++;
    if (got !== exp) begin
      n_fail++; $display("[TB] FAIL match_a5: got %b, want %b", got, exp);
    end
  endtask

  task automatic test_mismatch();
    do_clr();
    drive(1'b1, 4'h3, 8'hA5, 8'h00, 1'b0);
    drive(1'b0, 4'h3, 8'h00, 8'h00, 1'b0);
    idle(1, 8'h00);
    got = snap(); exp = 12'h000; n_cmp++;
    if (got !== exp) begin
      n_fail++; $display("[TB] FAIL mismatch_issue_plus1: got %b, want %b", got, exp);
    end
    idle(1, 8'h5A);
    got = snap(); exp = {1'b1, 1'b0, 1'b0, 1'b1, 4'h3, 2'd1, 2'd1}; n_cmp++;
    if (got !== exp) begin
      n_fail++; $display("[TB] FAIL mismatch_issue_plus2: got %b, want %b", got, exp);
    end
  endtask

  task automatic test_addr_range();
    do_clr();
    drive(1'b1, 4'h2, 8'h11, 8'h00, 1'b0);
    drive(1'b0, 4'h2, 8'h00, 8'h00, 1'b0);
    drive(1'b0, 4'h9, 8'h00, 8'h00, 1'b0);
    idle(1, 8'h22);
    idle(1, 8'h00);
    got = snap(); exp = {1'b1, 1'b0, 1'b1, 1'b1, 4'h2, 2'd2, 2'd2}; n_cmp++;
    if (got !== exp) begin
      n_fail++; $display("[TB] FAIL errs_addr2_addr9: got %b, want %b", got, exp);
    end
  endtask

  task automatic test_clr();
    do_clr();
    got = snap(); exp = 12'h000; n_cmp++;
    if (got !== exp) begin
      n_fail++; $display("[TB] FAIL clr_pulse: got %b, want %b", got, exp);
    end
  endtask

  task automatic test_wr_oor();
    drive(1'b1, 4'h9, 8'h77, 8'h00, 1'b0);
    got = snap(); exp = {1'b0, 1'b0, 1'b1, 1'b1, 4'h9, 2'd1, 2'd0}; n_cmp++;
    if (got !== exp) begin
      n_fail++; $display("[TB] FAIL write_addr9: got %b, want %b", got, exp);
    end
    do_clr();
    drive(1'b0, 4'h1, 8'h00, 8'h00, 1'b0);
    idle(2, 8'h77);
    got = snap(); exp = {1'b0, 1'b1, 1'b0, 1'b1, 4'h1, 2'd1, 2'd1}; n_cmp++;
    if (got !== exp) begin
      n_fail++; $display("[TB] FAIL no_alias_addr1: got %b, want %b", got, exp);
    end
  endtask

  task automatic test_clr_wins();
    do_clr();
    drive(1'b1, 4'h3, 8'hA5, 8'h00, 1'b0);
    drive(1'b0, 4'h3, 8'h00, 8'h00, 1'b0);
    idle(1, 8'h00);
    drive(1'b1, 4'h0, 8'h00, 8'h00, 1'b1);
    got = snap(); exp = 12'h000; n_cmp++;
    if (got !== exp) begin
      n_fail++; $display("[TB] FAIL clr_with_error: got %b, want %b", got, exp);
    end
    idle(1, 8'h00);
    got = snap(); exp = 12'h000; n_cmp++;
    if (got !== exp) begin
      n_fail++; $display("[TB] FAIL clr_with_error_after: got %b, want %b", got, exp);
    end
  endtask

  task automatic test_back_to_back();
    do_clr();
    drive(1'b1, 4'h4, 8'h44, 8'h00, 1'b0);
    drive(1'b1, 4'h6, 8'h66, 8'h00, 1'b0);
    drive(1'b0, 4'h4, 8'h00, 8'h00, 1'b0);
    drive(1'b0, 4'h6, 8'h00, 8'h00, 1'b0);
    idle(1, 8'h44);
    idle(1, 8'h66);
    got = snap(); exp = {1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 2'd0, 2'd2}; n_cmp++;
    if (got !== exp) begin
      n_fail++; $display("[TB] FAIL back_to_back: got %b, want %b", got, exp);
    end
  endtask

  task automatic test_reset_inflight();
    do_clr();
    drive(1'b1, 4'h5, 8'h33, 8'h00, 1'b0);
    drive(1'b0, 4'h5, 8'h00, 8'h00, 1'b0);
    drive(1'b0, 4'h5, 8'h00, 8'h00, 1'b0);
    rst   = 1'b0;
    wren  = 1'b1;
    addr  = 4'h0;
    d_out = 8'h00;
    #1;
    got = snap(); exp = 12'h000; n_cmp++;
    if (got !== exp) begin
      n_fail++; $display("[TB] FAIL inflight_in_reset: got %b, want %b", got, exp);
    end
    idle(2, 8'h00);
    rst = 1'b1;
    idle(3, 8'h33);
    got = snap(); exp = 12'h000; n_cmp++;
    if (got !== exp) begin
      n_fail++; $display("[TB] FAIL inflight_discarded: got %b, want %b", got, exp);
    end
    drive(1'b0, 4'h5, 8'h00, 8'h00, 1'b0);
    idle(2, 8'h33);
    got = snap(); exp = {1'b0, 1'b1, 1'b0, 1'b1, 4'h5, 2'd1, 2'd1}; n_cmp++;
    if (got !== exp) begin
      n_fail++; $display("[TB] FAIL valid_cleared_by_reset: got %b, want %b", got, exp);
    end
  endtask

  task automatic test_saturation();
    do_clr();
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 4'h9, 8'h00, 8'h00, 1'b0);
    end
    got = snap(); exp = {1'b0, 1'b0, 1'b1, 1'b1, 4'h9, 2'd2, 2'd2}; n_cmp++;
    if (got !== exp) begin
      n_fail++; $display("[TB] FAIL sat_two_errors: got %b, want %b", got, exp);
    end
    drive(1'b0, 4'h9, 8'h00, 8'h00, 1'b0);
    got = snap(); exp = {1'b0, 1'b0, 1'b1, 1'b1, 4'h9, 2'd3, 2'd3}; n_cmp++;
    if (got !== exp) begin
      n_fail++; $display("[TB] FAIL sat_three_errors: got %b, want %b", got, exp);
    end
    idle(2, 8'h00);
    got = snap(); exp = {1'b0, 1'b0, 1'b1, 1'b1, 4'h9, 2'd3, 2'd3}; n_cmp++;
    if (got !== exp) begin
      n_fail++; $display("[TB] FAIL sat_five_errors: got %b, want %b", got, exp);
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_uninit();
    test_match();
    test_mismatch();
    test_addr_range();
    test_clr();
    test_wr_oor();
    test_clr_wins();
    test_back_to_back();
    test_reset_inflight();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
